// File: rtl/seg_scan_controller.sv
// rtl/seg_scan_controller.sv - four-digit hex scan driver for a common-anode 7-segment display
// Optional macro LEADING_ZERO_BLANK_EN turns off leading-zero digits (digit 0 always shows).
module seg_scan_controller #(
  parameter int DIGIT_TICKS = 50000,
  parameter int BLANK_TICKS = 500
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Enable,
  input  logic [15:0] ValueIn,
  input  logic        Load,
  output logic [3:0]  DigitEn,
  output logic [6:0]  Seg,
  output logic        FrameDone,
  output logic        UpdatePending
);

  localparam int MaxTicks = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
  localparam int CntW = $clog2(MaxTicks + 1);
  localparam logic [CntW-1:0] DigitLast = CntW'(DIGIT_TICKS - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_TICKS - 1);

  typedef enum logic {Blank, Show} ScanState;

  ScanState        state;
  logic [CntW-1:0] tickCnt;
  logic [1:0]      index;
  logic [15:0]     staging;
  logic [15:0]     shadow;

  function automatic logic [6:0] hexSegs(input logic [3:0] nib);
    case (nib)
      4'h0: hexSegs = 7'b1111110;
      4'h1: hexSegs = 7'b0110000;
      4'h2: hexSegs = 7'b1101101;
      4'h3: hexSegs = 7'b1111001;
      4'h4: hexSegs = 7'b0110011;
      4'h5: hexSegs = 7'b1011011;
      4'h6: hexSegs = 7'b1011111;
      4'h7: hexSegs = 7'b1110000;
      4'h8: hexSegs = 7'b1111111;
      4'h9: hexSegs = 7'b1111011;
      4'hA: hexSegs = 7'b1110111;
      4'hB: hexSegs = 7'b0011111;
      4'hC: hexSegs = 7'b1001110;
      4'hD: hexSegs = 7'b0111101;
      4'hE: hexSegs = 7'b1001111;
      default: hexSegs = 7'b1000111;
    endcase
  endfunction

  // Active-low segment pattern for digit idx of val.
  function automatic logic [6:0] digitSegs(input logic [15:0] val, input logic [1:0] idx);
    logic [15:0] upper;
    upper = val >> {idx, 2'b00};
    digitSegs = ~hexSegs(upper[3:0]);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx != 2'd0 && upper == 16'h0000) digitSegs = 7'b1111111;
`endif
  endfunction

  function automatic logic [3:0] digitSelect(input logic [1:0] idx);
    digitSelect = 4'b1111;
    digitSelect[idx] = 1'b0;
  endfunction

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state         <= Blank;
      tickCnt       <= '0;
      index         <= 2'd0;
      staging       <= 16'h0000;
      shadow        <= 16'h0000;
      DigitEn       <= 4'b1111;
      Seg           <= 7'b1111111;
      FrameDone     <= 1'b0;
      UpdatePending <= 1'b0;
    end else begin
      FrameDone <= 1'b0;
      if (!Enable) begin
        state   <= Blank;
        tickCnt <= '0;
        index   <= 2'd0;
        DigitEn <= 4'b1111;
        Seg     <= 7'b1111111;
      end else begin
        case (state)
          Blank: begin
            if (tickCnt == BlankLast) begin
              state   <= Show;
              tickCnt <= '0;
              DigitEn <= digitSelect(index);
              Seg     <= digitSegs(shadow, index);
            end else begin
              tickCnt <= tickCnt + CntW'(1);
            end
          end
          Show: begin
            if (tickCnt == DigitLast) begin
              state   <= Blank;
              tickCnt <= '0;
              index   <= index + 2'd1;
              DigitEn <= 4'b1111;
              Seg     <= 7'b1111111;
              // Shadow only moves between frames, so a frame never mixes two values.
              if (index == 2'd3) begin
                FrameDone <= 1'b1;
                if (UpdatePending) begin
                  shadow        <= staging;
                  UpdatePending <= 1'b0;
                end
              end
            end else begin
              tickCnt <= tickCnt + CntW'(1);
            end
          end
          default: state <= Blank;
        endcase
      end
      // A load on the commit edge overrides the clear above and stays pending.
      if (Load) begin
        staging       <= ValueIn;
        UpdatePending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// tb/tb_seg_scan_controller.sv - scoreboard bench for seg_scan_controller (DIGIT_TICKS=4, BLANK_TICKS=2)
module tb_seg_scan_controller;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Enable = 1'b1;
  logic [15:0] ValueIn = 16'h0000;
  logic        Load = 1'b0;
  logic [3:0]  DigitEn;
  logic [6:0]  Seg;
  logic        FrameDone;
  logic        UpdatePending;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int lastFrame = -1;
  logic [3:0] prevDigitEn = 4'b1111;
  logic [10:0] expQ[$];

  // Active-low hex patterns, inverted by hand from the abcdefg table.
  logic [6:0] segTab[16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  seg_scan_controller #(.DIGIT_TICKS(4), .BLANK_TICKS(2)) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .ValueIn(ValueIn), .Load(Load),
    .DigitEn(DigitEn), .Seg(Seg), .FrameDone(FrameDone), .UpdatePending(UpdatePending)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic pushDigits(input logic [15:0] val, input int count);
    for (int i = 0; i < count; i++) begin
      logic [3:0] en;
      logic [6:0] sg;
      logic [15:0] upper;
      en = 4'b1111;
      en[i] = 1'b0;
      upper = val >> (4 * i);
      sg = segTab[upper[3:0]];
`ifdef LEADING_ZERO_BLANK_EN
      if (i != 0 && upper == 16'h0000) sg = 7'b1111111;
`endif
      expQ.push_back({en, sg});
    end
  endtask

  task automatic loadValue(input logic [15:0] val);
    ValueIn = val;
    Load = 1'b1;
    tick();
    Load = 1'b0;
  endtask

  task automatic waitFrame(input string name);
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      if (FrameDone === 1'b1) seen = 1;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: FrameDone got 0 expected 1 within 60 cycles", name);
    end
  endtask

  // Monitor: each time a digit lights, pop the next expected {DigitEn, Seg}.
  always @(negedge Clock) begin
    cycle++;
    if (Reset) begin
      prevDigitEn = 4'b1111;
      lastFrame = -1;
    end else begin
      if (prevDigitEn == 4'b1111 && DigitEn != 4'b1111) begin
        vectors++;
        if (expQ.size() == 0) begin
          miscompares++;
          $display("FAIL digit_unexpected: got %b/%b expected no digit", DigitEn, Seg);
        end else begin
          logic [10:0] e;
          e = expQ.pop_front();
          if ({DigitEn, Seg} !== e) begin
            miscompares++;
            $display("FAIL digit: got %b/%b expected %b/%b", DigitEn, Seg, e[10:7], e[6:0]);
          end
        end
      end
      prevDigitEn = DigitEn;
      if (!Enable) lastFrame = -1;
      else if (FrameDone) begin
        if (lastFrame >= 0) begin
          vectors++;
          if (cycle - lastFrame != 24) begin
            miscompares++;
            $display("FAIL frame_period: got %0d expected 24", cycle - lastFrame);
          end
        end
        lastFrame = cycle;
      end
    end
  end

  initial begin
    tick();
    check("reset_digiten", 16'(DigitEn), 16'hF);
    check("reset_seg", 16'(Seg), 16'h7F);
    check("reset_framedone", 16'(FrameDone), 16'h0);
    check("reset_pending", 16'(UpdatePending), 16'h0);
    Reset = 1'b0;

    // Frames 1-2 show zeros; load 1A3F mid frame 2.
    pushDigits(16'h0000, 4);
    waitFrame("frame1");
    pushDigits(16'h0000, 4);
    repeat (5) tick();
    loadValue(16'h1A3F);
    check("pending_after_load", 16'(UpdatePending), 16'h1);
    waitFrame("frame2");
    check("pending_cleared_1a3f", 16'(UpdatePending), 16'h0);

    // Frame 3 shows 1A3F; two loads, only the last survives.
    pushDigits(16'h1A3F, 4);
    repeat (3) tick();
    loadValue(16'h1111);
    repeat (3) tick();
    loadValue(16'h2222);
    waitFrame("frame3");
    check("pending_cleared_2222", 16'(UpdatePending), 16'h0);

    // Frame 4 shows 2222; 4444 pending, 5555 loaded on the frame-end edge.
    pushDigits(16'h2222, 4);
    repeat (5) tick();
    loadValue(16'h4444);
    repeat (17) tick();
    ValueIn = 16'h5555;
    Load = 1'b1;
    tick();
    Load = 1'b0;
    check("collide_framedone", 16'(FrameDone), 16'h1);
    check("collide_pending", 16'(UpdatePending), 16'h1);
    pushDigits(16'h4444, 4);
    waitFrame("frame5");
    check("pending_cleared_5555", 16'(UpdatePending), 16'h0);

    // Frame 6 shows 5555 until Enable drops during digit 2.
    pushDigits(16'h5555, 3);
    repeat (15) tick();
    check("digit2_lit", 16'(DigitEn), 16'hB);
    Enable = 1'b0;
    tick();
    check("disable_digiten", 16'(DigitEn), 16'hF);
    check("disable_seg", 16'(Seg), 16'h7F);
    for (int i = 0; i < 10; i++) begin
      check("disable_no_framedone", 16'(FrameDone), 16'h0);
      tick();
    end
    pushDigits(16'h5555, 1);
    Enable = 1'b1;
    tick();
    check("reenable_blank", 16'(DigitEn), 16'hF);
    tick();
    check("reenable_digit0", 16'(DigitEn), 16'hE);
    check("reenable_seg", 16'(Seg), 16'(segTab[5]));

    // Asynchronous reset mid-SHOW discards a pending value.
    loadValue(16'h1234);
    check("pending_before_reset", 16'(UpdatePending), 16'h1);
    #2;
    Reset = 1'b1;
    #1;
    check("async_digiten", 16'(DigitEn), 16'hF);
    check("async_seg", 16'(Seg), 16'h7F);
    check("async_pending", 16'(UpdatePending), 16'h0);
    tick();
    Reset = 1'b0;

    pushDigits(16'h0000, 4);
    loadValue(16'h00A0);
    waitFrame("frame_after_reset");
    check("pending_cleared_00a0", 16'(UpdatePending), 16'h0);
    pushDigits(16'h00A0, 4);
    waitFrame("frame_00a0");
    check("queue_drained", 16'(expQ.size()), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_scan_controller.md
Name: seg_scan_controller

Overview:
- Time-multiplexes a 16-bit register value as four hex digits onto one shared 7-segment decoder and a 4-digit common-anode display.
- Sits between the 16-bit register/ALU result and the board display pins.
- Sequences digit select, inter-digit blanking and tear-free value updates.
- All board-facing outputs are active-low.

Parameters:
- DIGIT_TICKS, 50000, clock cycles each digit is lit; must be ≥1.
- BLANK_TICKS, 500, clock cycles all digits are dark between digits (anti-ghosting); must be ≥1.

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Enable  input  1  1 = scanning runs; 0 = display forced dark.
- ValueIn  input  16  value to display; [15:12] shows on digit 3 (leftmost), [3:0] on digit 0.
- Load  input  1  single-cycle strobe that captures ValueIn into staging.
- DigitEn  output  4  active-low anode selects; bit n drives digit n.
- Seg  output  7  active-low segments; Seg[6]=a, Seg[5]=b … Seg[0]=g.
- FrameDone  output  1  one-cycle pulse at the end of each full 4-digit scan.
- UpdatePending  output  1  high while a staged value awaits commit.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is asynchronous and active-high; on assertion all outputs change immediately, without waiting for an edge.
- Reset values:
  - DigitEn=4'b1111, Seg=7'b1111111, FrameDone=0, UpdatePending=0.
  - Shadow and staging registers = 16'h0000.
  - Digit index = 0, tick counter = 0, state = BLANK.
- Internal registers:
  - Tick counter, width $clog2(max(DIGIT_TICKS,BLANK_TICKS)+1).
  - 2-bit digit index.
  - Staging and shadow 16-bit registers.
  - All outputs are registered.
- State BLANK:
  - DigitEn=1111, Seg=1111111.
  - Stays BLANK_TICKS cycles, then moves to SHOW; counter clears on every transition.
- State SHOW:
  - DigitEn bit [index]=0, all others 1.
  - Seg = active-low hex decode of shadow nibble [index].
  - Stays DIGIT_TICKS cycles, then moves to BLANK and index increments mod 4 (3 wraps to 0).
- Output timing: outputs change on the same edge the state is entered.
  - BLANK lasts exactly BLANK_TICKS cycles; SHOW lasts exactly DIGIT_TICKS cycles.
  - Frame period = 4*(BLANK_TICKS+DIGIT_TICKS) cycles.
- Frame end (SHOW→BLANK leaving index 3), all on one edge:
  - FrameDone pulses high for exactly 1 cycle.
  - If UpdatePending=1: shadow ← staging and UpdatePending ← 0.
- Load handling:
  - Load=1 on an edge: staging ← ValueIn, UpdatePending ← 1.
  - Loads are accepted in every state and regardless of Enable; the last Load before commit wins.
  - Load coinciding with a frame-end commit: shadow takes the previous staging value; staging takes the new ValueIn; UpdatePending stays 1.
  - The shadow register never changes mid-frame, so no digit tearing occurs.
- Hex decode, active-high abcdefg (Seg = bitwise inverse):
  - 0:1111110  1:0110000  2:1101101  3:1111001
  - 4:0110011  5:1011011  6:1011111  7:1110000
  - 8:1111111  9:1111011  A:1110111  b:0011111
  - C:1001110  d:0111101  E:1001111  F:1000111
- Enable=0:
  - Synchronously forces state BLANK, index 0, counter 0, DigitEn=1111, Seg=1111111.
  - No FrameDone and no commit while disabled.
  - On re-enable, scanning restarts with a full BLANK_TICKS period before digit 0.
- Reset mid-SHOW: display goes dark at once; any pending staged value is discarded.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: in SHOW, a digit whose nibble and all higher-order nibbles are 0 shows all segments off (Seg=1111111) but keeps its DigitEn select and timing.
  - Digit 0 always displays, so 16'h0000 shows a single "0".
  - 16'h00A0 lights only digits 1 and 0.
- Not defined: all four digits always display, including leading zeros.

Test Plan (DIGIT_TICKS=4, BLANK_TICKS=2, frame=24 cycles):
- Reset, Enable=1, no Load → DigitEn cycles 1110,1101,1011,0111 with 2-cycle 1111 gaps; Seg=0000001 ("0") in every SHOW; FrameDone every 24 cycles.
- Load ValueIn=16'h1A3F mid-frame → UpdatePending=1 until the frame end; next frame shows digit3=1001111 ("1"), digit2=0001000 ("A"), digit1=0000110 ("3"), digit0=0111000 ("F").
- Load 16'h1111 then 16'h2222 in the same frame → only 2222 is ever displayed; UpdatePending clears at the frame end.
- Load 16'h5555 on the exact FrameDone edge while 16'h4444 is pending → next frame shows 4444, UpdatePending stays 1, the following frame shows 5555.
- Drop Enable during SHOW of digit 2 → next cycle DigitEn=1111, Seg=1111111, no FrameDone; raise Enable → 2 blank cycles, then digit 0 lit.
- Assert Reset asynchronously mid-SHOW → DigitEn=1111, Seg=1111111, UpdatePending=0 before the next clock edge; with LEADING_ZERO_BLANK_EN and 16'h00A0 loaded → digits 3 and 2 show Seg=1111111.
